hdmi_period_scheduler: RTL and testbench

Sequences the HDMI TMDS period structure for the 720x480@60 transmitter. It sits between the raster counters and the three channel encoder/serializers. Each pixel clock it decides the period:
- control
- video preamble and guard band
- active video
- data-island preamble, guard band and packet

It drives the CTL bus and the per-period select to the encoders. It also round-robin arbitrates packet sources (audio sample, audio clock regeneration, InfoFrame) for island slots.

---
 rtl/hdmi_pkg.sv | 34 +++
 rtl/hdmi_rr_arbiter.sv | 47 ++++
 rtl/hdmi_period_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared period encodings, CTL patterns and island timing constants for the HDMI period scheduler.
// Pure declarations: no latency, no flow control.
package hdmi_pkg;

    typedef enum logic [2:0] {
        PERIOD_CONTROL   = 3'd0,
        PERIOD_VIDEO_PRE = 3'd1,
        PERIOD_VIDEO_GB  = 3'd2,
        PERIOD_VIDEO     = 3'd3,
        PERIOD_DATA_PRE  = 3'd4,
        PERIOD_DATA_GB   = 3'd5,
        PERIOD_DATA      = 3'd6
    } period_t;

    typedef enum logic [2:0] {
        ISL_IDLE     = 3'd0,
        ISL_PRE      = 3'd1,
        ISL_GB_LEAD  = 3'd2,
        ISL_SLOT     = 3'd3,
        ISL_GB_TRAIL = 3'd4
    } island_state_t;

    localparam logic [3:0] CTL_IDLE      = 4'b0000;
    localparam logic [3:0] VIDEO_PRE_CTL = 4'b0001;
    localparam logic [3:0] DATA_PRE_CTL  = 4'b0101;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;

    // Longest island: preamble, two guard bands and two packet slots.
    localparam int ISLAND_MAX_LEN = PREAMBLE_LEN + 2 * GUARD_LEN + 2 * PACKET_LEN;

endpackage

// File: rtl/hdmi_rr_arbiter.sv
// Round-robin packet-source arbiter: combinational one-hot grant, pointer moves past the winner on advance.
// Zero-cycle grant; no backpressure, requesters hold req until their grant falls.
module hdmi_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            winner;

    // Pass 0 searches at/above the pointer, pass 1 wraps to the lowest index.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        winner = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (pass == 1 || i >= int'(ptr_q))) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    winner   = i;
                end
            end
        end
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (winner == NUM_REQ - 1) ? '0 : PW'(winner + 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// TMDS period sequencer for 720x480@60; data islands and packet arbitration exist only with HDMI_SCHED_DATA_ISLAND_EN (else DVI).
// One-cycle registered latency from hPos/vPos; no backpressure, island timing is free-running once launched.
module hdmi_period_scheduler #(
    parameter int H_ACTIVE    = 720,
    parameter int H_TOTAL     = 858,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int NUM_REQ     = 3,
    parameter int MAX_PACKETS = 2
) (
    input  logic               pixelClock,
    input  logic               reset,
    input  logic [9:0]         hPosCounter,
    input  logic [9:0]         vPosCounter,
    input  logic [NUM_REQ-1:0] packetReq,
    output logic [NUM_REQ-1:0] packetGrant,
    output logic [4:0]         packetCycle,
    output logic [2:0]         periodType,
    output logic [3:0]         ctl
);
    import hdmi_pkg::*;

    // The island must finish with 12 control cycles to spare before the video preamble.
    if (H_ACTIVE + 4 + ISLAND_MAX_LEN + 12 > H_TOTAL - 10) begin : g_bad_island_timing
        $error("data island does not fit in horizontal blanking");
    end
    if (MAX_PACKETS < 1 || MAX_PACKETS > 2) begin : g_bad_max_packets
        $error("MAX_PACKETS must be 1 or 2");
    end

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_PRE    = 10'(H_TOTAL - 10);
    localparam logic [9:0] H_GB     = 10'(H_TOTAL - 2);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    logic       next_active;
    period_t    vid_period;
    logic [3:0] vid_ctl;
    period_t    period_q, period_d;
    logic [3:0] ctl_q, ctl_d;

    always_comb begin
        next_active = (vPosCounter == V_LAST) || (vPosCounter < V_ACT_M1);
        vid_period  = PERIOD_CONTROL;
        vid_ctl     = CTL_IDLE;
        if (hPosCounter < H_ACT && vPosCounter < V_ACT) begin
            vid_period = PERIOD_VIDEO;
        end else if (next_active && hPosCounter >= H_PRE && hPosCounter < H_GB) begin
            vid_period = PERIOD_VIDEO_PRE;
            vid_ctl    = VIDEO_PRE_CTL;
        end else if (next_active && hPosCounter >= H_GB) begin
            vid_period = PERIOD_VIDEO_GB;
        end
    end

`ifdef HDMI_SCHED_DATA_ISLAND_EN
    localparam logic [9:0] H_DECIDE = 10'(H_ACTIVE + 4);

    island_state_t      state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [1:0]         slots_q, slots_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, arb_grant;
    logic [4:0]         pcycle_q, pcycle_d;
    logic               arb_adv;

    hdmi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (pixelClock),
        .rst     (reset),
        .req     (packetReq),
        .advance (arb_adv),
        .grant   (arb_grant)
    );

    // cnt_q counts down the remaining cycles of the current island phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slots_d = slots_q;
        grant_d = grant_q;
        arb_adv = 1'b0;
        case (state_q)
            ISL_IDLE: begin
                if (hPosCounter == H_DECIDE && packetReq != '0) begin
                    state_d = ISL_PRE;
                    cnt_d   = 5'(PREAMBLE_LEN - 1);
                    slots_d = 2'd0;
                end
            end
            ISL_PRE: begin
                if (cnt_q == 5'd0) begin
                    state_d = ISL_GB_LEAD;
                    cnt_d   = 5'(GUARD_LEN - 1);
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ISL_GB_LEAD: begin
                if (cnt_q == 5'd0) begin
                    state_d = ISL_SLOT;
                    cnt_d   = 5'(PACKET_LEN - 1);
                    arb_adv = 1'b1;
                    grant_d = arb_grant;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ISL_SLOT: begin
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else if (slots_q < 2'(MAX_PACKETS - 1) && packetReq != '0) begin
                    cnt_d   = 5'(PACKET_LEN - 1);
                    slots_d = slots_q + 2'd1;
                    arb_adv = 1'b1;
                    grant_d = arb_grant;
                end else begin
                    state_d = ISL_GB_TRAIL;
                    cnt_d   = 5'(GUARD_LEN - 1);
                    grant_d = '0;
                end
            end
            ISL_GB_TRAIL: begin
                if (cnt_q == 5'd0) begin
                    state_d = ISL_IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                state_d = ISL_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs follow the next island state so they land with one-cycle latency.
    always_comb begin
        period_d = vid_period;
        ctl_d    = vid_ctl;
        pcycle_d = 5'd0;
        case (state_d)
            ISL_PRE: begin
                period_d = PERIOD_DATA_PRE;
                ctl_d    = DATA_PRE_CTL;
            end
            ISL_GB_LEAD, ISL_GB_TRAIL: begin
                period_d = PERIOD_DATA_GB;
                ctl_d    = CTL_IDLE;
            end
            ISL_SLOT: begin
                period_d = PERIOD_DATA;
                ctl_d    = CTL_IDLE;
                pcycle_d = 5'(PACKET_LEN - 1) - cnt_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            state_q  <= ISL_IDLE;
            cnt_q    <= 5'd0;
            slots_q  <= 2'd0;
            grant_q  <= '0;
            pcycle_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slots_q  <= slots_d;
            grant_q  <= grant_d;
            pcycle_q <= pcycle_d;
        end
    end

    assign packetGrant = grant_q;
    assign packetCycle = pcycle_q;
`else
    logic unused_req;

    assign unused_req  = ^packetReq;
    assign period_d    = vid_period;
    assign ctl_d       = vid_ctl;
    assign packetGrant = '0;
    assign packetCycle = 5'd0;
`endif

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            period_q <= PERIOD_CONTROL;
            ctl_q    <= CTL_IDLE;
        end else begin
            period_q <= period_d;
            ctl_q    <= ctl_d;
        end
    end

    assign periodType = period_q;
    assign ctl        = ctl_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler; island scenarios run when HDMI_SCHED_DATA_ISLAND_EN is defined.
module tb_hdmi_period_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hpos, vpos;
    logic [2:0] preq;
    logic [2:0] packetGrant;
    logic [4:0] packetCycle;
    logic [2:0] periodType;
    logic [3:0] ctl;

    int n_checks = 0;
    int n_pass   = 0;

    // Outputs recorded per line, indexed by the hPos sampled on the edge that produced them.
    logic [2:0] per_a [0:857];
    logic [3:0] ctl_a [0:857];
    logic [2:0] gnt_a [0:857];
    logic [4:0] pc_a  [0:857];

    hdmi_period_scheduler dut (
        .pixelClock  (clk),
        .reset       (rst),
        .hPosCounter (hpos),
        .vPosCounter (vpos),
        .packetReq   (preq),
        .packetGrant (packetGrant),
        .packetCycle (packetCycle),
        .periodType  (periodType),
        .ctl         (ctl)
    );

    always #5 clk = ~clk;

    task automatic step(input int h, input int v, input logic [2:0] req);
        hpos = 10'(h);
        vpos = 10'(v);
        preq = req;
        @(posedge clk);
        #1;
        per_a[h] = periodType;
        ctl_a[h] = ctl;
        gnt_a[h] = packetGrant;
        pc_a[h]  = packetCycle;
    endtask

    task automatic run_range(input int v, input int h0, input int h1, input logic [2:0] req, input int drop_h);
        for (int h = h0; h <= h1; h++) begin
            step(h, v, (h < drop_h) ? req : 3'b000);
        end
    endtask

    function automatic logic [2:0] exp_vid_per(input int h, input int v);
        bit nxt;
        nxt = (v == 524) || (v < 479);
        if (h < 720 && v < 480) return 3'd3;
        if (nxt && h >= 848 && h <= 855) return 3'd1;
        if (nxt && h >= 856) return 3'd2;
        return 3'd0;
    endfunction

    // Counts recorded-output deviations from the expected line; an island launches at index 724.
    task automatic count_line_errors(input int v, input bit isl, input logic [2:0] g1, input logic [2:0] g2,
                                     input int nslots, output int e_per, output int e_ctl,
                                     output int e_gnt, output int e_pc);
        int         off, len;
        logic [2:0] ep, eg;
        logic [3:0] ec;
        logic [4:0] epc;
        len = 12 + 32 * nslots;
        e_per = 0; e_ctl = 0; e_gnt = 0; e_pc = 0;
        for (int h = 0; h < 858; h++) begin
            off = h - 724;
            ep  = exp_vid_per(h, v);
            ec  = (ep == 3'd1) ? 4'b0001 : 4'b0000;
            eg  = 3'b000;
            epc = 5'd0;
            if (isl && off >= 0 && off < len) begin
                ec = 4'b0000;
                if (off < 8) begin
                    ep = 3'd4;
                    ec = 4'b0101;
                end else if (off < 10) begin
                    ep = 3'd5;
                end else if (off < 10 + 32 * nslots) begin
                    ep  = 3'd6;
                    eg  = ((off - 10) / 32 == 0) ? g1 : g2;
                    epc = 5'((off - 10) % 32);
                end else begin
                    ep = 3'd5;
                end
            end
            if (per_a[h] !== ep)  e_per++;
            if (ctl_a[h] !== ec)  e_ctl++;
            if (gnt_a[h] !== eg)  e_gnt++;
            if (pc_a[h]  !== epc) e_pc++;
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        hpos = 10'd0;
        vpos = 10'd0;
        preq = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (periodType !== 3'd0) $display("FAIL reset periodType: got %0d expected 0", periodType); else n_pass++;
        n_checks++; if (ctl !== 4'd0) $display("FAIL reset ctl: got %b expected 0000", ctl); else n_pass++;
        n_checks++; if (packetGrant !== 3'd0) $display("FAIL reset grant: got %b expected 000", packetGrant); else n_pass++;
        n_checks++; if (packetCycle !== 5'd0) $display("FAIL reset packetCycle: got %0d expected 0", packetCycle); else n_pass++;
        rst = 1'b0;
        step(0, 0, 3'b000);
        n_checks++; if (per_a[0] !== 3'd3) $display("FAIL first cycle after reset: got %0d expected 3", per_a[0]); else n_pass++;
    endtask

    task automatic test_video_raster();
        int lines [5];
        int pre_exp [5];
        int e_per, e_ctl, e_gnt, e_pc, npre;
        lines   = '{478, 479, 480, 524, 0};
        pre_exp = '{8, 0, 0, 8, 8};
        for (int k = 0; k < 5; k++) begin
            run_range(lines[k], 0, 857, 3'b000, 1023);
            count_line_errors(lines[k], 1'b0, 3'b000, 3'b000, 0, e_per, e_ctl, e_gnt, e_pc);
            npre = 0;
            for (int h = 0; h < 858; h++) if (per_a[h] == 3'd1) npre++;
            n_checks++; if (e_per != 0) $display("FAIL video line %0d period: got %0d bad cycles expected 0", lines[k], e_per); else n_pass++;
            n_checks++; if (e_ctl != 0) $display("FAIL video line %0d ctl: got %0d bad cycles expected 0", lines[k], e_ctl); else n_pass++;
            n_checks++; if (e_gnt + e_pc != 0) $display("FAIL video line %0d packet outputs: got %0d bad cycles expected 0", lines[k], e_gnt + e_pc); else n_pass++;
            n_checks++; if (npre != pre_exp[k]) $display("FAIL video line %0d preamble length: got %0d expected %0d", lines[k], npre, pre_exp[k]); else n_pass++;
        end
    endtask

`ifndef HDMI_SCHED_DATA_ISLAND_EN
    task automatic test_dvi_mode();
        int lines [2];
        int e_per, e_ctl, e_gnt, e_pc, maxp;
        lines = '{300, 524};
        for (int k = 0; k < 2; k++) begin
            run_range(lines[k], 0, 857, 3'b111, 1023);
            count_line_errors(lines[k], 1'b0, 3'b000, 3'b000, 0, e_per, e_ctl, e_gnt, e_pc);
            maxp = 0;
            for (int h = 0; h < 858; h++) if (int'(per_a[h]) > maxp) maxp = int'(per_a[h]);
            n_checks++; if (e_per != 0) $display("FAIL dvi line %0d period: got %0d bad cycles expected 0", lines[k], e_per); else n_pass++;
            n_checks++; if (e_gnt != 0) $display("FAIL dvi line %0d grant: got %0d nonzero cycles expected 0", lines[k], e_gnt); else n_pass++;
            n_checks++; if (e_pc != 0) $display("FAIL dvi line %0d packetCycle: got %0d nonzero cycles expected 0", lines[k], e_pc); else n_pass++;
            n_checks++; if (maxp > 3) $display("FAIL dvi line %0d max periodType: got %0d expected <=3", lines[k], maxp); else n_pass++;
        end
    endtask
`else
    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_island_single_source();
        int e_per, e_ctl, e_gnt, e_pc;
        run_range(100, 0, 857, 3'b001, 1023);
        count_line_errors(100, 1'b1, 3'b001, 3'b001, 2, e_per, e_ctl, e_gnt, e_pc);
        n_checks++; if (e_per != 0) $display("FAIL island 001 period: got %0d bad cycles expected 0", e_per); else n_pass++;
        n_checks++; if (e_ctl != 0) $display("FAIL island 001 ctl: got %0d bad cycles expected 0", e_ctl); else n_pass++;
        n_checks++; if (e_gnt != 0) $display("FAIL island 001 grant: got %0d bad cycles expected 0", e_gnt); else n_pass++;
        n_checks++; if (e_pc != 0) $display("FAIL island 001 packetCycle: got %0d bad cycles expected 0", e_pc); else n_pass++;
        n_checks++; if (per_a[724] !== 3'd4 || ctl_a[724] !== 4'b0101) $display("FAIL island first preamble: got %0d/%b expected 4/0101", per_a[724], ctl_a[724]); else n_pass++;
        n_checks++; if (gnt_a[734] !== 3'b001 || pc_a[734] !== 5'd0) $display("FAIL island slot start: got %b/%0d expected 001/0", gnt_a[734], pc_a[734]); else n_pass++;
        n_checks++; if (gnt_a[798] !== 3'b000) $display("FAIL grant drop after last word: got %b expected 000", gnt_a[798]); else n_pass++;
    endtask

    task automatic test_round_robin();
        int lines [2];
        logic [2:0] g1 [2];
        logic [2:0] g2 [2];
        int e_per, e_ctl, e_gnt, e_pc;
        lines = '{200, 201};
        g1    = '{3'b001, 3'b100};
        g2    = '{3'b010, 3'b001};
        pulse_reset();
        for (int k = 0; k < 2; k++) begin
            run_range(lines[k], 0, 857, 3'b111, 1023);
            count_line_errors(lines[k], 1'b1, g1[k], g2[k], 2, e_per, e_ctl, e_gnt, e_pc);
            n_checks++; if (e_per + e_ctl != 0) $display("FAIL rr line %0d period/ctl: got %0d bad cycles expected 0", lines[k], e_per + e_ctl); else n_pass++;
            n_checks++; if (e_gnt != 0) $display("FAIL rr line %0d grant: got %0d bad cycles expected 0 (first %b second %b)", lines[k], e_gnt, gnt_a[734], gnt_a[766]); else n_pass++;
            n_checks++; if (e_pc != 0) $display("FAIL rr line %0d packetCycle: got %0d bad cycles expected 0", lines[k], e_pc); else n_pass++;
        end
    endtask

    task automatic test_drop_after_slot();
        int e_per, e_ctl, e_gnt, e_pc;
        run_range(202, 0, 857, 3'b010, 766);
        count_line_errors(202, 1'b1, 3'b010, 3'b000, 1, e_per, e_ctl, e_gnt, e_pc);
        n_checks++; if (e_per + e_ctl != 0) $display("FAIL drop period/ctl: got %0d bad cycles expected 0", e_per + e_ctl); else n_pass++;
        n_checks++; if (e_gnt + e_pc != 0) $display("FAIL drop grant/packetCycle: got %0d bad cycles expected 0", e_gnt + e_pc); else n_pass++;
        n_checks++; if (per_a[766] !== 3'd5) $display("FAIL drop trail guard at island cycle 42: got %0d expected 5", per_a[766]); else n_pass++;
        n_checks++; if (per_a[768] !== 3'd0) $display("FAIL drop island end at cycle 44: got %0d expected 0", per_a[768]); else n_pass++;
    endtask

    task automatic test_reset_mid_island();
        int e_per, e_ctl, e_gnt, e_pc, bad;
        pulse_reset();
        run_range(10, 0, 744, 3'b001, 1023);
        n_checks++; if (pc_a[744] !== 5'd10 || gnt_a[744] !== 3'b001) $display("FAIL pre-reset slot: got %0d/%b expected 10/001", pc_a[744], gnt_a[744]); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (periodType !== 3'd0 || ctl !== 4'd0) $display("FAIL mid-island reset period/ctl: got %0d/%b expected 0/0000", periodType, ctl); else n_pass++;
        n_checks++; if (packetGrant !== 3'd0 || packetCycle !== 5'd0) $display("FAIL mid-island reset grant/cycle: got %b/%0d expected 000/0", packetGrant, packetCycle); else n_pass++;
        for (int h = 745; h <= 748; h++) step(h, 10, 3'b001);
        rst = 1'b0;
        run_range(10, 749, 857, 3'b001, 1023);
        bad = 0;
        for (int h = 749; h < 858; h++) if (gnt_a[h] !== 3'b000 || per_a[h] >= 3'd4) bad++;
        n_checks++; if (bad != 0) $display("FAIL island after reset release: got %0d island cycles expected 0", bad); else n_pass++;
        n_checks++; if (per_a[850] !== 3'd1) $display("FAIL preamble after reset: got %0d expected 1", per_a[850]); else n_pass++;
        run_range(11, 0, 857, 3'b001, 1023);
        count_line_errors(11, 1'b1, 3'b001, 3'b001, 2, e_per, e_ctl, e_gnt, e_pc);
        n_checks++; if (e_per + e_ctl != 0) $display("FAIL line after reset period/ctl: got %0d bad cycles expected 0", e_per + e_ctl); else n_pass++;
        n_checks++; if (e_gnt + e_pc != 0) $display("FAIL line after reset grant/cycle: got %0d bad cycles expected 0", e_gnt + e_pc); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_video_raster();
`ifndef HDMI_SCHED_DATA_ISLAND_EN
        test_dvi_mode();
`else
        test_island_single_source();
        test_round_robin();
        test_drop_after_slot();
        test_reset_mid_island();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
